mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of the word-addressed data memory.
- Takes byte-addressed CPU load/store requests (byte, half, word) and converts them into one-cycle read/write strobes on the memory's re/we/address/data_w/data_r/rdy interface.
- Performs lane extraction with sign or zero extension for loads.
- Performs read-modify-write for sub-word stores, and reports misalignment and memory timeout.

Parameters:
- TIMEOUT, 16, max cycles spent waiting for mem_rdy in a WAIT state before aborting with error.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_req  input  1  request strobe, sampled only in IDLE
- cpu_we  input  1  1 = store, 0 = load
- cpu_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- cpu_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend
- cpu_addr  input  32  byte address
- cpu_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- cpu_busy  output  1  high whenever state != IDLE
- cpu_done  output  1  one-cycle pulse, transaction complete
- cpu_rdata  output  32  load result, valid while cpu_done=1
- cpu_err  output  1  valid with cpu_done: misaligned/illegal size or timeout
- mem_re  output  1  memory read strobe
- mem_we  output  1  memory write strobe
- mem_address  output  32  word address = {2'b00, addr[31:2]}
- mem_data_w  output  32  memory write data
- mem_data_r  input  32  memory read data
- mem_rdy  input  1  memory ready; drops when a strobe rises, returns high after the servicing edge

Behaviour:
- Reset (rst=0, asynchronous):
  - State forced to IDLE.
  - mem_re, mem_we, cpu_busy, cpu_done and cpu_err are forced to 0 immediately, without waiting for a clock edge.
  - cpu_rdata, mem_address, mem_data_w and the timeout counter are cleared to 0.
- Request accept:
  - In IDLE with cpu_req=1, cpu_addr/size/signed/we/wdata are registered at the edge.
  - CPU inputs are ignored until the unit returns to IDLE; requests are never queued.
- Alignment check at accept:
  - Error cases: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - Next state is DONE with cpu_err=1 and cpu_rdata=0; no memory strobe is issued.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, DONE.
  - Word store: IDLE -> WR_ISSUE -> WR_WAIT -> DONE.
  - Load: IDLE -> RD_ISSUE -> RD_WAIT -> DONE.
  - Byte/half store (RMW): IDLE -> RD_ISSUE -> RD_WAIT -> WR_ISSUE -> WR_WAIT -> DONE.
  - DONE -> IDLE unconditionally after one cycle.
- ISSUE states:
  - The matching strobe is high for exactly that one cycle.
  - mem_rdy is ignored in ISSUE states.
- WAIT states:
  - Strobes are low.
  - mem_address and mem_data_w are held stable from ISSUE through the end of WAIT.
  - mem_rdy=1 sampled at an edge completes the access.
  - In RD_WAIT, mem_data_r is captured on that same edge.
- Latency, with the request accepted at edge A, cpu_done high in the cycle after:
  - Word load/store: edge A+2 (three cycles total).
  - Sub-word store: edge A+4.
  - Misaligned request: edge A.
- Load extraction (little-endian, lane = addr[1:0], lane 0 = [7:0]):
  - Byte uses bits [8*lane+7 : 8*lane].
  - Half uses [15:0] when addr[1]=0, [31:16] when addr[1]=1.
  - Result is extended to 32 bits according to cpu_signed.
- Store merge:
  - The captured read word has only the addressed lane(s) replaced by cpu_wdata[7:0] or [15:0].
  - The result is driven on mem_data_w in WR_ISSUE.
  - Word store drives cpu_wdata unchanged, with no read.
- Timeout:
  - The counter resets on entry to each WAIT state and increments each cycle mem_rdy=0.
  - When it reaches TIMEOUT: go to DONE with cpu_err=1 and cpu_rdata=0.
  - For RMW, a timeout in RD_WAIT skips the write entirely.
- cpu_rdata is 0 for stores; it holds its value after DONE until the next DONE.
- Reset mid-transaction:
  - The transaction is abandoned and no cpu_done is produced.
  - A partially completed RMW leaves memory unmodified (the write has not yet been issued) or fully written (WR_WAIT already entered).

Test Plan:
1. Word store 0xDEADBEEF to 0x10:
   - Required: mem_we high for 1 cycle, mem_address=0x4, mem_data_w=0xDEADBEEF, cpu_done at A+2, err=0.
   - Then word load from 0x10 -> cpu_rdata=0xDEADBEEF.
2. Loads from word 0x10 (=0xDEADBEEF):
   - Byte, addr 0x13, signed -> 0xFFFFFFDE.
   - Same unsigned -> 0x000000DE.
   - Half, addr 0x12, signed -> 0xFFFFDEAD.
   - Byte, addr 0x10, unsigned -> 0x000000EF.
3. Byte store 0x55 to 0x11:
   - Required: mem_re pulse, then mem_we pulse with mem_data_w=0xDEAD55EF, cpu_done at A+4.
   - Subsequent word load -> 0xDEAD55EF.
4. Misaligned requests (word load at 0x12, half store at 0x13, size=11):
   - Required: cpu_done next cycle, cpu_err=1, mem_re/mem_we never asserted.
5. Memory model holds mem_rdy=0 after a read strobe, TIMEOUT=16:
   - Required: cpu_done with cpu_err=1 after 16 cycles in RD_WAIT, cpu_rdata=0.
   - A byte-store variant in the same condition: mem_we never asserted.
6. rst driven low during RD_WAIT:
   - Required: mem_re/mem_we/cpu_busy go to 0 without a clock edge, and no cpu_done.
   - After release, a new word load completes normally in 3 cycles.

Source files
------------

// File: rtl/mem_access_if.sv
// Bundle of CPU-side request/response and memory-side strobe signals for mem_access_unit.
// The slave modport is the unit itself; the master modport is the CPU plus memory environment.
interface mem_access_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_data_w;
    logic [31:0] mem_data_r;
    logic        mem_rdy;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata, mem_data_r, mem_rdy,
        output cpu_busy, cpu_done, cpu_rdata, cpu_err, mem_re, mem_we, mem_address, mem_data_w
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata, mem_data_r, mem_rdy,
        input  cpu_busy, cpu_done, cpu_rdata, cpu_err, mem_re, mem_we, mem_address, mem_data_w
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory: lane extraction,
// sub-word read-modify-write, misalignment detection and memory timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic         clk,
    input logic         rst,
    mem_access_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t             state_q,   state_d;
    logic [1:0]         lane_q,    lane_d;
    logic [1:0]         size_q,    size_d;
    logic               sgn_q,     sgn_d;
    logic               req_we_q,  req_we_d;
    logic [15:0]        wdata_q,   wdata_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;
    logic               mem_re_q,  mem_re_d;
    logic               mem_we_q,  mem_we_d;
    logic [31:0]        rdata_q,   rdata_d;
    logic [31:0]        address_q, address_d;
    logic [31:0]        data_w_q,  data_w_d;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic r;
        case (size)
            2'b00:   r = 1'b0;
            2'b01:   r = lane[0];
            2'b10:   r = (lane != 2'b00);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Only the addressed lane(s) of the freshly read word are replaced by store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic [15:0] d);
        logic [31:0] r;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    r = {word[31:8], d[7:0]};
                    2'd1:    r = {word[31:16], d[7:0], word[7:0]};
                    2'd2:    r = {word[31:24], d[7:0], word[15:0]};
                    default: r = {d[7:0], word[23:0]};
                endcase
            end
            2'b01:   r = lane[1] ? {d, word[15:0]} : {word[31:16], d};
            default: r = word;
        endcase
        return r;
    endfunction

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        size_d    = size_q;
        sgn_d     = sgn_q;
        req_we_d  = req_we_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        rdata_d   = rdata_q;
        address_d = address_q;
        data_w_d  = data_w_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req) begin
                    lane_d    = bus.cpu_addr[1:0];
                    size_d    = bus.cpu_size;
                    sgn_d     = bus.cpu_signed;
                    req_we_d  = bus.cpu_we;
                    wdata_d   = bus.cpu_wdata[15:0];
                    address_d = {2'b00, bus.cpu_addr[31:2]};
                    data_w_d  = bus.cpu_wdata;
                    if (is_misaligned(bus.cpu_size, bus.cpu_addr[1:0])) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (bus.cpu_we && (bus.cpu_size == 2'b10)) begin
                        state_d  = WR_ISSUE;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d  = RD_ISSUE;
                        mem_re_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_ISSUE: begin
                state_d = RD_WAIT;
                cnt_d   = CNT_W'(0);
            end
            RD_WAIT: begin
                if (bus.mem_rdy) begin
                    if (req_we_q) begin
                        state_d  = WR_ISSUE;
                        mem_we_d = 1'b1;
                        data_w_d = store_merge(bus.mem_data_r, lane_q, size_q, wdata_q);
                    end else begin
                        state_d = DONE;
                        rdata_d = load_extract(bus.mem_data_r, lane_q, size_q, sgn_q);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WR_ISSUE: begin
                state_d = WR_WAIT;
                cnt_d   = CNT_W'(0);
            end
            WR_WAIT: begin
                if (bus.mem_rdy) begin
                    state_d = DONE;
                    rdata_d = 32'd0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops; reset clears every output without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            lane_q    <= 2'd0;
            size_q    <= 2'd0;
            sgn_q     <= 1'b0;
            req_we_q  <= 1'b0;
            wdata_q   <= 16'd0;
            cnt_q     <= CNT_W'(0);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            rdata_q   <= 32'd0;
            address_q <= 32'd0;
            data_w_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            size_q    <= size_d;
            sgn_q     <= sgn_d;
            req_we_q  <= req_we_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            rdata_q   <= rdata_d;
            address_q <= address_d;
            data_w_q  <= data_w_d;
        end
    end

    assign bus.cpu_busy    = busy_q;
    assign bus.cpu_done    = done_q;
    assign bus.cpu_err     = err_q;
    assign bus.cpu_rdata   = rdata_q;
    assign bus.mem_re      = mem_re_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_address = address_q;
    assign bus.mem_data_w  = data_w_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: word-memory model with optional stall,
// expected results queued per request and compared when cpu_done appears.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    mem_access_if bus();

    mem_access_unit #(.TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          re_n;
        int          we_n;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          re_n;
        int          we_n;
        logic        pulse_ok;
    } obs_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Memory model: one-cycle strobe service, mem_rdy low while stalled after a strobe.
    logic [31:0] mem [0:63];
    logic [31:0] rd_q = 32'd0;
    logic        rdy_r = 1'b1;
    logic        stall = 1'b0;
    int          re_total = 0;
    int          we_total = 0;
    int          done_total = 0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_wdata = 32'd0;
    int          re_base, we_base;

    assign bus.mem_data_r = rd_q;
    assign bus.mem_rdy    = rdy_r & ~(bus.mem_re | bus.mem_we);

    always @(posedge clk) begin
        if (bus.mem_re) begin
            rd_q     <= mem[bus.mem_address[5:0]];
            re_total <= re_total + 1;
        end
        if (bus.mem_we) begin
            mem[bus.mem_address[5:0]] <= bus.mem_data_w;
            we_total   <= we_total + 1;
            last_waddr <= bus.mem_address;
            last_wdata <= bus.mem_data_w;
        end
        if (bus.mem_re || bus.mem_we) rdy_r <= ~stall;
        else if (!stall)              rdy_r <= 1'b1;
        if (bus.cpu_done) done_total <= done_total + 1;
    end

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                                input int re_n, input int we_n);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat; e.re_n = re_n; e.we_n = we_n;
        return e;
    endfunction

    task automatic send(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
        sb.push_back(e);
        @(negedge clk);
        re_base = re_total;
        we_base = we_total;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_size = size;
        bus.cpu_signed = sgn; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_done(input string nm, output obs_t o);
        int n = 0;
        while (!bus.cpu_done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.cpu_done) begin
            checks++; errors++;
            $display("FAIL %s no cpu_done within 40 cycles", nm);
            o.lat = -1;
        end else begin
            o.lat = n;
        end
        o.rdata = bus.cpu_rdata;
        o.err   = bus.cpu_err;
        o.re_n  = re_total - re_base;
        o.we_n  = we_total - we_base;
        @(posedge clk);
        #1;
        o.pulse_ok = !bus.cpu_done && !bus.cpu_busy;
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #1;
        checks += 8;
        if (bus.cpu_busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got %b want 0", bus.cpu_busy); end
        if (bus.cpu_done !== 1'b0)        begin errors++; $display("FAIL rst_done got %b want 0", bus.cpu_done); end
        if (bus.cpu_err !== 1'b0)         begin errors++; $display("FAIL rst_err got %b want 0", bus.cpu_err); end
        if (bus.mem_re !== 1'b0)          begin errors++; $display("FAIL rst_re got %b want 0", bus.mem_re); end
        if (bus.mem_we !== 1'b0)          begin errors++; $display("FAIL rst_we got %b want 0", bus.mem_we); end
        if (bus.cpu_rdata !== 32'd0)      begin errors++; $display("FAIL rst_rdata got %h want 0", bus.cpu_rdata); end
        if (bus.mem_address !== 32'd0)    begin errors++; $display("FAIL rst_addr got %h want 0", bus.mem_address); end
        if (bus.mem_data_w !== 32'd0)     begin errors++; $display("FAIL rst_wdata got %h want 0", bus.mem_data_w); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word_rw();
        obs_t o; exp_t e;
        send(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, mk(32'd0, 1'b0, 2, 0, 1));
        wait_done("word_store", o);
        e = sb.pop_front();
        checks += 8;
        if (o.rdata !== e.rdata)        begin errors++; $display("FAIL ws_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.err !== e.err)            begin errors++; $display("FAIL ws_err got %b want %b", o.err, e.err); end
        if (o.lat !== e.lat)            begin errors++; $display("FAIL ws_latency got %0d want %0d", o.lat, e.lat); end
        if (o.re_n !== e.re_n)          begin errors++; $display("FAIL ws_re_count got %0d want %0d", o.re_n, e.re_n); end
        if (o.we_n !== e.we_n)          begin errors++; $display("FAIL ws_we_count got %0d want %0d", o.we_n, e.we_n); end
        if (o.pulse_ok !== 1'b1)        begin errors++; $display("FAIL ws_done_pulse got %b want 1", o.pulse_ok); end
        if (last_waddr !== 32'h4)       begin errors++; $display("FAIL ws_mem_address got %h want 4", last_waddr); end
        if (last_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ws_mem_data_w got %h want deadbeef", last_wdata); end
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, mk(32'hDEADBEEF, 1'b0, 2, 1, 0));
        wait_done("word_load", o);
        e = sb.pop_front();
        checks += 4;
        if (o.rdata !== e.rdata)        begin errors++; $display("FAIL wl_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.err !== e.err)            begin errors++; $display("FAIL wl_err got %b want %b", o.err, e.err); end
        if (o.lat !== e.lat)            begin errors++; $display("FAIL wl_latency got %0d want %0d", o.lat, e.lat); end
        if (o.re_n !== e.re_n)          begin errors++; $display("FAIL wl_re_count got %0d want %0d", o.re_n, e.re_n); end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
        logic        sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] ex [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h000000EF};
        obs_t o; exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, sz[i], sg[i], ad[i], 32'd0, mk(ex[i], 1'b0, 2, 1, 0));
            wait_done("load", o);
            e = sb.pop_front();
            checks += 3;
            if (o.rdata !== e.rdata) begin errors++; $display("FAIL load%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
            if (o.err !== e.err)     begin errors++; $display("FAIL load%0d_err got %b want %b", i, o.err, e.err); end
            if (o.lat !== e.lat)     begin errors++; $display("FAIL load%0d_latency got %0d want %0d", i, o.lat, e.lat); end
        end
    endtask

    task automatic test_rmw();
        obs_t o; exp_t e;
        send(1'b1, 2'b00, 1'b0, 32'h11, 32'h00000055, mk(32'd0, 1'b0, 4, 1, 1));
        wait_done("byte_store", o);
        e = sb.pop_front();
        checks += 7;
        if (o.rdata !== e.rdata)        begin errors++; $display("FAIL rmw_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.err !== e.err)            begin errors++; $display("FAIL rmw_err got %b want %b", o.err, e.err); end
        if (o.lat !== e.lat)            begin errors++; $display("FAIL rmw_latency got %0d want %0d", o.lat, e.lat); end
        if (o.re_n !== e.re_n)          begin errors++; $display("FAIL rmw_re_count got %0d want %0d", o.re_n, e.re_n); end
        if (o.we_n !== e.we_n)          begin errors++; $display("FAIL rmw_we_count got %0d want %0d", o.we_n, e.we_n); end
        if (last_waddr !== 32'h4)       begin errors++; $display("FAIL rmw_mem_address got %h want 4", last_waddr); end
        if (last_wdata !== 32'hDEAD55EF) begin errors++; $display("FAIL rmw_mem_data_w got %h want dead55ef", last_wdata); end
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, mk(32'hDEAD55EF, 1'b0, 2, 1, 0));
        wait_done("rmw_readback", o);
        e = sb.pop_front();
        checks += 1;
        if (o.rdata !== e.rdata)        begin errors++; $display("FAIL rmw_readback got %h want %h", o.rdata, e.rdata); end
    endtask

    task automatic test_misaligned();
        logic        wv [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'h12, 32'h13, 32'h10};
        obs_t o; exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(wv[i], sz[i], 1'b0, ad[i], 32'h12345678, mk(32'd0, 1'b0 | 1'b1, 0, 0, 0));
            wait_done("misaligned", o);
            e = sb.pop_front();
            checks += 6;
            if (o.rdata !== e.rdata)  begin errors++; $display("FAIL mis%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
            if (o.err !== e.err)      begin errors++; $display("FAIL mis%0d_err got %b want %b", i, o.err, e.err); end
            if (o.lat !== e.lat)      begin errors++; $display("FAIL mis%0d_latency got %0d want %0d", i, o.lat, e.lat); end
            if (o.re_n !== e.re_n)    begin errors++; $display("FAIL mis%0d_re_count got %0d want %0d", i, o.re_n, e.re_n); end
            if (o.we_n !== e.we_n)    begin errors++; $display("FAIL mis%0d_we_count got %0d want %0d", i, o.we_n, e.we_n); end
            if (o.pulse_ok !== 1'b1)  begin errors++; $display("FAIL mis%0d_done_pulse got %b want 1", i, o.pulse_ok); end
        end
    endtask

    task automatic test_timeout();
        logic        wv [2] = '{1'b0, 1'b1};
        logic [1:0]  sz [2] = '{2'b10, 2'b00};
        logic [31:0] ad [2] = '{32'h10, 32'h11};
        obs_t o; exp_t e;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send(wv[i], sz[i], 1'b0, ad[i], 32'h000000AA, mk(32'd0, 1'b1, 17, 1, 0));
            wait_done("timeout", o);
            e = sb.pop_front();
            checks += 5;
            if (o.rdata !== e.rdata)  begin errors++; $display("FAIL to%0d_rdata got %h want %h", i, o.rdata, e.rdata); end
            if (o.err !== e.err)      begin errors++; $display("FAIL to%0d_err got %b want %b", i, o.err, e.err); end
            if (o.lat !== e.lat)      begin errors++; $display("FAIL to%0d_latency got %0d want %0d", i, o.lat, e.lat); end
            if (o.re_n !== e.re_n)    begin errors++; $display("FAIL to%0d_re_count got %0d want %0d", i, o.re_n, e.re_n); end
            if (o.we_n !== e.we_n)    begin errors++; $display("FAIL to%0d_we_count got %0d want %0d", i, o.we_n, e.we_n); end
        end
        stall = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        obs_t o; exp_t e;
        int   done_base;
        stall = 1'b1;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'b10;
        bus.cpu_signed = 1'b0; bus.cpu_addr = 32'h10;
        @(posedge clk); #1; bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        done_base = done_total;
        checks += 1;
        if (bus.cpu_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b want 1", bus.cpu_busy); end
        rst = 1'b0;
        #1;
        checks += 5;
        if (bus.mem_re !== 1'b0)       begin errors++; $display("FAIL mid_re got %b want 0", bus.mem_re); end
        if (bus.mem_we !== 1'b0)       begin errors++; $display("FAIL mid_we got %b want 0", bus.mem_we); end
        if (bus.cpu_busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got %b want 0", bus.cpu_busy); end
        if (bus.cpu_done !== 1'b0)     begin errors++; $display("FAIL mid_done got %b want 0", bus.cpu_done); end
        if (bus.mem_address !== 32'd0) begin errors++; $display("FAIL mid_addr got %h want 0", bus.mem_address); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks += 1;
        if (done_total !== done_base) begin errors++; $display("FAIL mid_no_done got %0d want %0d", done_total, done_base); end
        send(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, mk(32'hDEAD55EF, 1'b0, 2, 1, 0));
        wait_done("post_reset_load", o);
        e = sb.pop_front();
        checks += 3;
        if (o.rdata !== e.rdata) begin errors++; $display("FAIL post_rdata got %h want %h", o.rdata, e.rdata); end
        if (o.err !== e.err)     begin errors++; $display("FAIL post_err got %b want %b", o.err, e.err); end
        if (o.lat !== e.lat)     begin errors++; $display("FAIL post_latency got %0d want %0d", o.lat, e.lat); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'b00;
        bus.cpu_signed = 1'b0; bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0;
        test_reset();
        test_word_rw();
        test_loads();
        test_rmw();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
